// File: rtl/pbvi_pkg.sv
// Shared constants and types for the PBVI pipeline stages.
package pbvi_pkg;
  localparam int N_ACTION = 3;
  localparam int N_POINT  = 16;
  localparam int N_STATE  = 2;
  localparam int W        = 16;

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W:0]   value_t;
  typedef logic [1:0]     act_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/pbvi_dot2.sv
// Two-element unsigned dot product, full precision (W x W -> 2W+1).
module pbvi_dot2 #(
  parameter int W = pbvi_pkg::W
) (
  input  logic [W-1:0] g0,
  input  logic [W-1:0] g1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic [2*W:0] value
);
  logic [2*W-1:0] prod0;
  logic [2*W-1:0] prod1;

  always_comb begin
    prod0 = (2*W)'(g0) * (2*W)'(b0);
    prod1 = (2*W)'(g1) * (2*W)'(b1);
    value = {1'b0, prod0} + {1'b0, prod1};
  end
endmodule

// File: rtl/pbvi_step3.sv
// PBVI backup selection: per belief point, keep the best-scoring action alpha.
//   state | meaning
//   IDLE  | waiting for en; running best cleared on start
//   RUN   | one (point, action) evaluation per clock, action fastest
module pbvi_step3 #(
  parameter int N_ACTION = pbvi_pkg::N_ACTION,
  parameter int N_POINT  = pbvi_pkg::N_POINT,
  parameter int N_STATE  = pbvi_pkg::N_STATE,
  parameter int W        = pbvi_pkg::W
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic [N_ACTION-1:0][N_POINT-1:0][N_STATE-1:0][W-1:0] gamma_action_bilief,
  input  logic [N_POINT-1:0][N_STATE-1:0][W-1:0]            point_belief,
  output logic [N_POINT-1:0][N_STATE-1:0][W-1:0]            alpha_new,
  output logic [N_POINT-1:0][1:0]                           best_action,
  output logic [N_POINT-1:0][2*W:0]                         point_value,
  output logic                                              busy,
  output logic                                              en_step4
);
  import pbvi_pkg::*;

  localparam int PT_W = $clog2(N_POINT);

  state_t                          state_q, state_d;
  logic [PT_W-1:0]                 pt_q, pt_d;
  act_t                            act_q, act_d;
  logic [2*W:0]                    best_val_q, best_val_d;
  act_t                            best_act_q, best_act_d;
  logic [N_STATE-1:0][W-1:0]       best_alpha_q, best_alpha_d;
  logic [N_POINT-1:0][N_STATE-1:0][W-1:0] alpha_new_q, alpha_new_d;
  logic [N_POINT-1:0][1:0]         best_action_q, best_action_d;
  logic [N_POINT-1:0][2*W:0]       point_value_q, point_value_d;
  logic                            en_step4_q, en_step4_d;

  logic [N_STATE-1:0][W-1:0]       cand_alpha;
  logic [N_STATE-1:0][W-1:0]       cur_belief;
  logic [2*W:0]                    cand_val;
  logic                            take;
  logic [2*W:0]                    sel_val;
  act_t                            sel_act;
  logic [N_STATE-1:0][W-1:0]       sel_alpha;

  assign cand_alpha = gamma_action_bilief[act_q][pt_q];
  assign cur_belief = point_belief[pt_q];

  pbvi_dot2 #(.W(W)) u_dot2 (
    .g0    (cand_alpha[0]),
    .g1    (cand_alpha[1]),
    .b0    (cur_belief[0]),
    .b1    (cur_belief[1]),
    .value (cand_val)
  );

  // Strict compare: on ties the lower action index, seen first, survives.
  always_comb begin
    take      = (act_q == '0) || (cand_val > best_val_q);
    sel_val   = take ? cand_val   : best_val_q;
    sel_act   = take ? act_q      : best_act_q;
    sel_alpha = take ? cand_alpha : best_alpha_q;
  end

  always_comb begin
    state_d       = state_q;
    pt_d          = pt_q;
    act_d         = act_q;
    best_val_d    = best_val_q;
    best_act_d    = best_act_q;
    best_alpha_d  = best_alpha_q;
    alpha_new_d   = alpha_new_q;
    best_action_d = best_action_q;
    point_value_d = point_value_q;
    en_step4_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = RUN;
          pt_d         = '0;
          act_d        = '0;
          best_val_d   = '0;
          best_act_d   = '0;
          best_alpha_d = '0;
        end
      end
      RUN: begin
        best_val_d   = sel_val;
        best_act_d   = sel_act;
        best_alpha_d = sel_alpha;
        if (act_q == act_t'(N_ACTION - 1)) begin
          alpha_new_d[pt_q]   = sel_alpha;
          best_action_d[pt_q] = sel_act;
          point_value_d[pt_q] = sel_val;
          act_d               = '0;
          pt_d                = pt_q + 1'b1;
          if (pt_q == PT_W'(N_POINT - 1)) begin
            state_d    = IDLE;
            en_step4_d = 1'b1;
          end
        end else begin
          act_d = act_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pt_q          <= '0;
      act_q         <= '0;
      best_val_q    <= '0;
      best_act_q    <= '0;
      best_alpha_q  <= '0;
      alpha_new_q   <= '0;
      best_action_q <= '0;
      point_value_q <= '0;
      en_step4_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pt_q          <= pt_d;
      act_q         <= act_d;
      best_val_q    <= best_val_d;
      best_act_q    <= best_act_d;
      best_alpha_q  <= best_alpha_d;
      alpha_new_q   <= alpha_new_d;
      best_action_q <= best_action_d;
      point_value_q <= point_value_d;
      en_step4_q    <= en_step4_d;
    end
  end

  assign alpha_new   = alpha_new_q;
  assign best_action = best_action_q;
  assign point_value = point_value_q;
  assign busy        = (state_q == RUN);
  assign en_step4    = en_step4_q;
endmodule
